// File: rtl/btn_pkg.sv
// Shared constants for the multi-channel button debouncer.
// Holds the stability-counter width, the prescaler divide helper and the default
// parameter values used by btn_debounce_multi, btn_debounce_chan and their bench.
package btn_pkg;

  localparam int unsigned CNT_W = 8;

  localparam int unsigned N_BTN_DEF        = 4;
  localparam int unsigned CLK_HZ_DEF       = 100_000_000;
  localparam int unsigned TICK_HZ_DEF      = 1_000;
  localparam int unsigned STABLE_TICKS_DEF = 8;
  localparam int unsigned LONG_TICKS_DEF   = 1_000;

  // Clock cycles per sample tick.
  function automatic int unsigned calc_div(input int unsigned clk_hz,
                                           input int unsigned tick_hz);
    return clk_hz / tick_hz;
  endfunction

endpackage

// File: rtl/btn_debounce_chan.sv
// One debounce channel: 2-FF synchroniser, tick-sampled stability counter, registered
// level and one-clock press/release pulses, plus an optional long-press detector.
// Optional feature macro: BTN_LONGPRESS_EN (without it long_o is tied to 0).
// Ports:
//   clk       - system clock
//   reset_n   - synchronous active-low reset
//   tick_i    - shared sample strobe, one clk wide
//   btn_i     - raw asynchronous button input, active-high
//   level_o   - debounced level
//   press_o   - one-clk pulse on accepted 0->1
//   release_o - one-clk pulse on accepted 1->0
//   long_o    - one-clk pulse once per press held LONG_TICKS ticks
module btn_debounce_chan
  import btn_pkg::*;
#(
  parameter int unsigned STABLE_TICKS = STABLE_TICKS_DEF,
  parameter int unsigned LONG_TICKS   = LONG_TICKS_DEF
) (
  input  logic clk,
  input  logic reset_n,
  input  logic tick_i,
  input  logic btn_i,
  output logic level_o,
  output logic press_o,
  output logic release_o,
  output logic long_o
);

  if (LONG_TICKS < 1) begin : gen_bad_long
    $error("LONG_TICKS must be at least 1");
  end

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(STABLE_TICKS - 1);

  logic             sync_meta_q, sync_meta_d;
  logic             sync_q, sync_d;
  logic             level_q, level_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             press_q, press_d;
  logic             release_q, release_d;

  always_comb begin
    sync_meta_d = btn_i;
    sync_d      = sync_meta_q;
    level_d     = level_q;
    cnt_d       = cnt_q;
    press_d     = 1'b0;
    release_d   = 1'b0;
    if (tick_i) begin
      if (sync_q == level_q) begin
        // Agreement with the current level (including a bounce back) restarts the count.
        cnt_d = '0;
      end else if (cnt_q == CntLast) begin
        level_d   = sync_q;
        cnt_d     = '0;
        press_d   = sync_q;
        release_d = ~sync_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync_meta_q <= 1'b0;
      sync_q      <= 1'b0;
      level_q     <= 1'b0;
      cnt_q       <= '0;
      press_q     <= 1'b0;
      release_q   <= 1'b0;
    end else begin
      sync_meta_q <= sync_meta_d;
      sync_q      <= sync_d;
      level_q     <= level_d;
      cnt_q       <= cnt_d;
      press_q     <= press_d;
      release_q   <= release_d;
    end
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;

`ifdef BTN_LONGPRESS_EN
  localparam int unsigned LongW = $clog2(LONG_TICKS + 1);
  localparam logic [LongW-1:0] LongMax = LongW'(LONG_TICKS);

  logic [LongW-1:0] long_cnt_q, long_cnt_d;
  logic             long_q, long_d;

  // Saturating hold counter; fires only on the tick that reaches LongMax, so no repeat.
  always_comb begin
    long_cnt_d = long_cnt_q;
    long_d     = 1'b0;
    if (!level_q) begin
      long_cnt_d = '0;
    end else if (tick_i && (long_cnt_q != LongMax)) begin
      long_cnt_d = long_cnt_q + 1'b1;
      long_d     = (long_cnt_d == LongMax);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      long_cnt_q <= '0;
      long_q     <= 1'b0;
    end else begin
      long_cnt_q <= long_cnt_d;
      long_q     <= long_d;
    end
  end

  assign long_o = long_q;
`else
  assign long_o = 1'b0;
`endif

endmodule

// File: rtl/btn_debounce_multi.sv
// Multi-channel push-button conditioner: one shared tick prescaler feeding N_BTN
// independent debounce channels.
// Optional feature macro: BTN_LONGPRESS_EN enables the per-channel long-press pulse.
// Ports:
//   clk       - system clock
//   reset_n   - synchronous active-low reset
//   i_btn     - raw asynchronous buttons, active-high
//   o_level   - debounced levels
//   o_press   - one-clk pulses on accepted presses
//   o_release - one-clk pulses on accepted releases
//   o_long    - one-clk long-press pulses (0 when the feature is not built)
module btn_debounce_multi
  import btn_pkg::*;
#(
  parameter int unsigned N_BTN        = N_BTN_DEF,
  parameter int unsigned CLK_HZ       = CLK_HZ_DEF,
  parameter int unsigned TICK_HZ      = TICK_HZ_DEF,
  parameter int unsigned STABLE_TICKS = STABLE_TICKS_DEF,
  parameter int unsigned LONG_TICKS   = LONG_TICKS_DEF
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [N_BTN-1:0] i_btn,
  output logic [N_BTN-1:0] o_level,
  output logic [N_BTN-1:0] o_press,
  output logic [N_BTN-1:0] o_release,
  output logic [N_BTN-1:0] o_long
);

  localparam int unsigned Div   = calc_div(CLK_HZ, TICK_HZ);
  localparam int unsigned TickW = $clog2(Div);
  localparam logic [TickW-1:0] TickLast = TickW'(Div - 1);

  if (Div < 2) begin : gen_bad_div
    $error("CLK_HZ/TICK_HZ must be at least 2");
  end
  if ((STABLE_TICKS < 1) || (STABLE_TICKS > 255)) begin : gen_bad_stable
    $error("STABLE_TICKS must be in 1..255");
  end

  logic [TickW-1:0] tick_cnt_q, tick_cnt_d;
  logic             tick;

  always_comb begin
    tick       = (tick_cnt_q == TickLast);
    tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      tick_cnt_q <= '0;
    end else begin
      tick_cnt_q <= tick_cnt_d;
    end
  end

  for (genvar i = 0; i < N_BTN; i++) begin : gen_chan
    btn_debounce_chan #(
      .STABLE_TICKS(STABLE_TICKS),
      .LONG_TICKS  (LONG_TICKS)
    ) u_chan (
      .clk      (clk),
      .reset_n  (reset_n),
      .tick_i   (tick),
      .btn_i    (i_btn[i]),
      .level_o  (o_level[i]),
      .press_o  (o_press[i]),
      .release_o(o_release[i]),
      .long_o   (o_long[i])
    );
  end

endmodule

// File: tb/tb_btn_debounce_multi.sv
// Bench for btn_debounce_multi: expected pulse events (bits plus allowed cycle window)
// are queued as stimulus is applied and matched against every pulse the DUT emits.
module tb_btn_debounce_multi;

  localparam int Div    = 10;
  localparam int Stable = 4;
  localparam int Long   = 20;
  localparam int LatLo  = 2 + (Stable - 1) * Div + 1;
  localparam int LatHi  = 2 + Stable * Div;
`ifdef BTN_LONGPRESS_EN
  localparam bit LongEn = 1'b1;
`else
  localparam bit LongEn = 1'b0;
`endif

  typedef struct {
    logic [3:0] press;
    logic [3:0] rel;
    logic [3:0] lng;
    int         lo;
    int         hi;
  } evt_t;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] i_btn;
  logic [3:0] o_level, o_press, o_release, o_long;

  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   last_evt_cyc = 0;
  logic [3:0] exp_level = 4'h0;
  evt_t sb[$];
  evt_t mon_e;
  logic [11:0] obs;

  btn_debounce_multi #(
    .N_BTN       (4),
    .CLK_HZ      (1000),
    .TICK_HZ     (100),
    .STABLE_TICKS(Stable),
    .LONG_TICKS  (Long)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .i_btn    (i_btn),
    .o_level  (o_level),
    .o_press  (o_press),
    .o_release(o_release),
    .o_long   (o_long)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic push_evt(input logic [3:0] p, input logic [3:0] r, input logic [3:0] l,
                          input int lo, input int hi);
    evt_t e;
    e.press = p;
    e.rel   = r;
    e.lng   = l;
    e.lo    = lo;
    e.hi    = hi;
    sb.push_back(e);
  endtask

  // Drive a new button vector and queue the event a clean step must produce.
  task automatic step(input logic [3:0] btn, input logic [3:0] p, input logic [3:0] r);
    i_btn = btn;
    push_evt(p, r, 4'h0, cyc + LatLo, cyc + LatHi);
  endtask

  task automatic drain(input string tag, input int budget);
    for (int i = 0; i < budget && sb.size() != 0; i++) @(negedge clk);
    @(negedge clk);
    check({tag, "_pending"}, 32'(sb.size()), 32'd0);
    sb.delete();
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Pulse monitor / scoreboard consumer.
  always @(negedge clk) begin
    if (!reset_n) exp_level = 4'h0;
    obs = {o_press, o_release, o_long};
    if (obs !== 12'h000 && ^obs !== 1'bx) begin
      if (sb.size() == 0) begin
        check("unexpected_pulse", 32'(obs), 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check("pulse_bits", 32'(obs), 32'({mon_e.press, mon_e.rel, mon_e.lng}));
        check($sformatf("pulse_in_window cyc=%0d lo=%0d hi=%0d", cyc, mon_e.lo, mon_e.hi),
              32'(cyc >= mon_e.lo && cyc <= mon_e.hi), 32'd1);
        exp_level = (exp_level | mon_e.press) & ~mon_e.rel;
        check("level_with_pulse", 32'(o_level), 32'(exp_level));
        last_evt_cyc = cyc;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    i_btn   = 4'hF;
    idle(5);
    check("rst_level", 32'(o_level), 32'd0);
    check("rst_press", 32'(o_press), 32'd0);
    check("rst_release", 32'(o_release), 32'd0);
    check("rst_long", 32'(o_long), 32'd0);

    // Buttons held through reset are accepted after the stability time.
    reset_n = 1'b1;
    push_evt(4'hF, 4'h0, 4'h0, cyc + LatLo, cyc + LatHi);
    drain("held_at_reset", 60);
    check("held_level", 32'(o_level), 32'hF);
    step(4'h0, 4'h0, 4'hF);
    drain("release_all", 60);

    // Clean press/release on ch1.
    step(4'h2, 4'h2, 4'h0);
    drain("ch1_press", 60);
    idle(100);
    check("ch1_hold_level", 32'(o_level), 32'h2);
    step(4'h0, 4'h0, 4'h2);
    drain("ch1_release", 60);
    check("ch1_rel_level", 32'(o_level), 32'h0);

    // Bounce on ch2: 7-clk toggles never survive enough ticks.
    for (int i = 0; i < 28; i++) begin
      i_btn[2] = ~i_btn[2];
      idle(7);
    end
    check("bounce_level", 32'(o_level), 32'h0);
    i_btn[2] = 1'b1;
    push_evt(4'h4, 4'h0, 4'h0, cyc + 1, cyc + LatHi);
    drain("bounce_settle", 60);
    step(4'h0, 4'h0, 4'h4);
    drain("bounce_release", 60);

    // Glitch on ch3 spanning at most 3 ticks.
    i_btn[3] = 1'b1;
    idle(3 * Div);
    i_btn[3] = 1'b0;
    idle(100);
    check("glitch_level", 32'(o_level), 32'h0);
    check("glitch_pending", 32'(sb.size()), 32'd0);

    // All channels in the same cycle.
    step(4'hF, 4'hF, 4'h0);
    drain("simul_press", 60);
    step(4'h0, 4'h0, 4'hF);
    drain("simul_release", 60);

    // Long press on ch0.
    step(4'h1, 4'h1, 4'h0);
    drain("long_press", 60);
    if (LongEn) begin
      push_evt(4'h0, 4'h0, 4'h1, last_evt_cyc + Long * Div, last_evt_cyc + Long * Div);
      drain("long_fire", Long * Div + 20);
    end else begin
      idle(Long * Div + 20);
    end
    idle(100 * Div);
    check("long_hold_level", 32'(o_level), 32'h1);

    // Reset mid-hold: everything clears, held button re-accepted, long rearmed.
    reset_n = 1'b0;
    idle(5);
    check("midrst_level", 32'(o_level), 32'd0);
    check("midrst_long", 32'(o_long), 32'd0);
    reset_n = 1'b1;
    push_evt(4'h1, 4'h0, 4'h0, cyc + LatLo, cyc + LatHi);
    drain("repress", 60);
    if (LongEn) begin
      push_evt(4'h0, 4'h0, 4'h1, last_evt_cyc + Long * Div, last_evt_cyc + Long * Div);
      drain("long_rearm", Long * Div + 20);
    end else begin
      idle(Long * Div + 20);
    end
    idle(50);
    step(4'h0, 4'h0, 4'h1);
    drain("long_release", 60);
    check("final_level", 32'(o_level), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/btn_debounce_multi.md
# btn_debounce_multi

Parametrised multi-channel push-button conditioner between the board button pins and the control FSMs. Each channel gets a 2-FF synchroniser and a tick-sampled stability counter, and produces a clean level plus one-clock press/release pulses in the `clk` domain. All channels share one tick prescaler. An optional long-press detector can be compiled in.

## Interface
- `N_BTN`, default 4: number of independent button channels.
- `CLK_HZ`, default 100_000_000: `clk` frequency.
- `TICK_HZ`, default 1_000: sample tick rate; `DIV = CLK_HZ/TICK_HZ`, must be ≥ 2.
- `STABLE_TICKS`, default 8: consecutive differing samples needed to accept a change; range 1..255.
- `LONG_TICKS`, default 1_000: ticks a press must be held before `o_long` fires; ≥ 1.

Ports:
- `clk` in 1: system clock.
- `reset_n` in 1: reset, synchronous, active-low.
- `i_btn` in `N_BTN`: raw asynchronous button inputs, active-high.
- `o_level` out `N_BTN`: debounced level.
- `o_press` out `N_BTN`: one-`clk` pulse on accepted 0→1.
- `o_release` out `N_BTN`: one-`clk` pulse on accepted 1→0.
- `o_long` out `N_BTN`: one-`clk` pulse on long press; tied 0 without `BTN_LONGPRESS_EN`.

## Operation
- **Prescaler**
  - Counter `tick_cnt` of width `$clog2(DIV)` counts 0..DIV-1 and wraps to 0.
  - `tick` is a combinational flag, true in the cycle where `tick_cnt == DIV-1`.
- **Synchroniser:** per channel, `i_btn` passes through 2 flops to give `s`.
- **Debounce (per channel)**
  - State: `level` and `cnt` (8 bit).
  - On `tick`, if `s == level`, then `cnt <= 0`.
  - On `tick`, if `s != level` and `cnt == STABLE_TICKS-1`, then `level <= s`, `cnt <= 0`, and the edge pulse is registered.
  - On `tick`, if `s != level` otherwise, `cnt <= cnt+1`.
  - When not `tick`, `cnt` holds.
  - Any bounce back to `level` during counting restarts the count.
- **Pulses**
  - `o_press` and `o_release` are registered.
  - They are high exactly in the first cycle in which the new `o_level` is visible, then drop to 0.
  - `o_press` and `o_release` are never both high on the same channel.
- **Channels:** independent; several channels may pulse in the same cycle.
- **Reset**
  - All flops clear at the first `clk` edge with `reset_n == 0`: `tick_cnt`, sync flops, `cnt`, long counters, and all outputs (`o_level = 0`, i.e. released).
  - A pulse in flight when reset is applied is dropped.
  - After release of reset, a button already held is accepted as a press after the normal stability time.

## Timing
- Prescaler restarts at 0 on the cycle after reset release; the first `tick` is at cycle DIV-1.
- Input step to `s`: 2 `clk`.
- Acceptance happens at the `STABLE_TICKS`-th consecutive tick sampling the new value.
- Worst-case step-to-`o_level` latency is `2 + STABLE_TICKS*DIV` clks; best case is `2 + (STABLE_TICKS-1)*DIV + 1`.
- Pulse width: exactly 1 `clk`.
- Output edges are aligned to the cycle after a `tick` cycle.

## Configuration
- **`BTN_LONGPRESS_EN` defined:**
  - Per channel, `long_cnt` (width `$clog2(LONG_TICKS+1)`) clears while `level == 0`.
  - While `level == 1` it increments on each `tick`, saturating at `LONG_TICKS`.
  - `o_long` pulses for 1 `clk` on the tick where `long_cnt` becomes `LONG_TICKS`. This is once per press, with no auto-repeat.
  - Release and re-press rearms it.
- **Undefined:** no `long_cnt` logic is built, and `o_long` is constant 0.

## Structure
- Package `btn_pkg` holds:
  - Width helper constants: `CNT_W = 8`, and the `DIV` derivation as a function.
  - Default parameter values, shared by top, sub-module and bench.
- Sub-module `btn_debounce_chan` holds one channel: synchroniser, stability counter, level/pulse registers, and optional long counter.
- The top holds the prescaler and a `generate` loop of `N_BTN` instances, each fed `tick`.

## Test plan
Bench parameters: `CLK_HZ=1000`, `TICK_HZ=100` (so DIV=10), `STABLE_TICKS=4`, `LONG_TICKS=20`, `N_BTN=4`.
- **Reset:** hold `reset_n=0` for 5 clks with `i_btn=4'hF` → all outputs 0. Release → `o_level[0]=1` and `o_press[0]=1` for 1 clk, no earlier than 2+3*DIV+1 clks and no later than 2+4*DIV clks after release.
- **Clean press/release on ch1:** step 0→1 → exactly one `o_press[1]` pulse. Hold for 100 clks, then step 1→0 → exactly one `o_release[1]` pulse, and `o_level[1]` follows.
- **Bounce:** toggle `i_btn[2]` every 7 clks for 200 clks, then settle at 1 → no pulse during toggling; a single `o_press[2]` ≤ 42 clks after settling.
- **Glitch rejection:** apply a high glitch of 3×DIV clks on ch3 → `o_level[3]` stays 0, no pulses.
- **Simultaneous:** step all channels 0→1 on the same clk → all four `o_press` bits pulse in the same cycle.
- **Long press (`BTN_LONGPRESS_EN`):**
  - Hold ch0 → `o_long[0]` pulses once, 20 ticks after `o_level[0]` rises.
  - Hold a further 100 ticks → no second pulse.
  - Mid-hold `reset_n=0` → `o_long` clears and no pulse appears until the channel is re-pressed and held 20 ticks.
